// File: rtl/mtm_alu_serializer_pkg.sv
// Shared frame constants, state encoding and CRC3 helper for the ALU serial link.
// The CRC function is also used by verification, so it stays free of module state.
package mtm_alu_pkg;

    localparam logic TYPE_DATA = 1'b0;
    localparam logic TYPE_CTL  = 1'b1;

    localparam int PKT_BITS     = 11;
    localparam int DATA_PKTS    = 4;
    localparam int PAYLOAD_BITS = PKT_BITS - 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_TYPE  = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // CRC3, polynomial x^3+x+1, 37 data bits processed MSB first.
    function automatic logic [2:0] nextCRC3_D37(input logic [36:0] data, input logic [2:0] crc);
        logic [2:0] c;
        logic       fb;
        c = crc;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ data[i];
            c  = {c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// Result/strobe bus from the ALU core plus the serial line and busy back-pressure.
interface mtm_alu_serializer_if;
    logic [31:0] C;
    logic [3:0]  FLAGS;
    logic [5:0]  ERR_FLAGS;
    logic        valid;
    logic        sout;
    logic        busy;

    modport master (output C, FLAGS, ERR_FLAGS, valid, input sout, busy);
    modport slave  (input C, FLAGS, ERR_FLAGS, valid, output sout, busy);
endinterface

// File: rtl/mtm_alu_serializer.sv
// Serialises one ALU result into 5 data/ctl packets, or 1 ctl packet on error.
// State | meaning: IDLE line high | START start bit | TYPE type bit | DATA 8 payload bits | STOP stop bit
module mtm_alu_serializer
    import mtm_alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mtm_alu_serializer_if.slave  bus
);

    localparam logic [2:0] BIT_TOP  = 3'(PAYLOAD_BITS - 1);
    localparam logic [2:0] LAST_PKT = 3'(DATA_PKTS);

    state_t      r_state,   w_state_nxt;
    logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [2:0]  r_pkt_cnt, w_pkt_cnt_nxt;
    logic        r_err,     w_err_nxt;
    logic [31:0] r_c,       w_c_nxt;
    logic [7:0]  r_ctl,     w_ctl_nxt;

    logic [2:0]  w_crc;
    logic        w_err_any;
    logic [7:0]  w_err_byte;
    logic        w_last;
    logic [7:0]  w_data_byte;
    logic [7:0]  w_payload;
    logic        w_sout;
    logic        w_busy;

    assign w_crc      = nextCRC3_D37({bus.C, 1'b0, bus.FLAGS}, 3'b000);
    assign w_err_any  = |bus.ERR_FLAGS;
    assign w_err_byte = {1'b1, bus.ERR_FLAGS, ^{1'b1, bus.ERR_FLAGS}};

    // An error frame is a single ctl packet, so its only packet is also the last.
    assign w_last     = r_err | (r_pkt_cnt == LAST_PKT);
    assign w_payload  = w_last ? r_ctl : w_data_byte;

    always_comb begin
        w_data_byte = r_c[31:24];
        case (r_pkt_cnt[1:0])
            2'd0:    w_data_byte = r_c[31:24];
            2'd1:    w_data_byte = r_c[23:16];
            2'd2:    w_data_byte = r_c[15:8];
            default: w_data_byte = r_c[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_pkt_cnt <= '0;
            r_err     <= 1'b0;
            r_c       <= '0;
            r_ctl     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_pkt_cnt <= w_pkt_cnt_nxt;
            r_err     <= w_err_nxt;
            r_c       <= w_c_nxt;
            r_ctl     <= w_ctl_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_pkt_cnt_nxt = r_pkt_cnt;
        w_err_nxt     = r_err;
        w_c_nxt       = r_c;
        w_ctl_nxt     = r_ctl;
        w_sout        = 1'b1;
        w_busy        = 1'b1;

        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.valid) begin
                    w_state_nxt   = ST_START;
                    w_bit_cnt_nxt = BIT_TOP;
                    w_pkt_cnt_nxt = '0;
                    w_err_nxt     = w_err_any;
                    w_c_nxt       = bus.C;
                    w_ctl_nxt     = w_err_any ? w_err_byte : {1'b0, bus.FLAGS, w_crc};
                end
            end
            ST_START: begin
                w_sout      = 1'b0;
                w_state_nxt = ST_TYPE;
            end
            ST_TYPE: begin
                w_sout      = w_last ? TYPE_CTL : TYPE_DATA;
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_sout = w_payload[r_bit_cnt];
                if (r_bit_cnt == 3'd0) begin
                    w_state_nxt = ST_STOP;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                end
            end
            ST_STOP: begin
                w_bit_cnt_nxt = BIT_TOP;
                if (w_last) begin
                    w_state_nxt   = ST_IDLE;
                    w_pkt_cnt_nxt = '0;
                end else begin
                    w_state_nxt   = ST_START;
                    w_pkt_cnt_nxt = r_pkt_cnt + 3'd1;
                end
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.sout = w_sout;
    assign bus.busy = w_busy;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Bench for mtm_alu_serializer: table vectors, hand-written corner sequences and a
// random CRC sweep checked against a packet-level reference built from the frame rules.
module tb_mtm_alu_serializer;
    import mtm_alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    mtm_alu_serializer_if bus();

    mtm_alu_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   cap[$];
    bit   exp_q[$];
    int   busy_cnt;
    bit   ended_idle;
    logic final_sout;

    typedef struct {
        logic [31:0] c;
        logic [3:0]  f;
        logic [5:0]  e;
        int          len;
        logic [7:0]  ctl;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Remainder of M(x)*x^3 divided by x^3+x+1, by long division.
    function automatic logic [2:0] ref_crc(input logic [31:0] c, input logic [3:0] f);
        logic [39:0] r;
        r = {c, 1'b0, f, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        return r[2:0];
    endfunction

    function automatic void push_pkt(input logic t, input logic [7:0] p);
        exp_q.push_back(1'b0);
        exp_q.push_back(t);
        for (int i = 7; i >= 0; i--) exp_q.push_back(p[i]);
        exp_q.push_back(1'b1);
    endfunction

    function automatic void build_exp(input logic [31:0] c, input logic [3:0] f, input logic [5:0] e);
        exp_q.delete();
        if (e != 6'd0) begin
            push_pkt(1'b1, {1'b1, e, 1'(($countones(e) + 1) % 2)});
        end else begin
            for (int k = 3; k >= 0; k--) push_pkt(1'b0, c[8*k +: 8]);
            push_pkt(1'b1, {1'b0, f, ref_crc(c, f)});
        end
    endfunction

    function automatic int mismatches();
        int m = 0;
        int n = (cap.size() > exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (i >= cap.size() || i >= exp_q.size() || cap[i] != exp_q[i]) m++;
        return m;
    endfunction

    function automatic logic [7:0] last_payload();
        logic [7:0] p = 8'h00;
        int s;
        if (cap.size() < 11) return 8'h00;
        s = cap.size() - 11;
        for (int i = 0; i < 8; i++) p[7-i] = cap[s+2+i];
        return p;
    endfunction

    // Called at a falling edge; records the line until busy drops (bounded).
    task automatic run_frame(input logic [31:0] c, input logic [3:0] f, input logic [5:0] e,
                             input int inj_at);
        bus.C         = c;
        bus.FLAGS     = f;
        bus.ERR_FLAGS = e;
        bus.valid     = 1'b1;
        @(posedge clk);
        #1 bus.valid = 1'b0;
        cap.delete();
        busy_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cap.push_back(bus.sout);
            busy_cnt++;
            if (i == inj_at) begin
                bus.valid = 1'b1;
                bus.C     = 32'hFFFF_FFFF;
                bus.FLAGS = 4'hF;
            end else if (i == inj_at + 1) begin
                bus.valid = 1'b0;
            end
        end
        ended_idle = !bus.busy;
        final_sout = bus.sout;
    endtask

    task automatic check_frame(input string tag, input logic [31:0] c, input logic [3:0] f,
                               input logic [5:0] e);
        build_exp(c, f, e);
        chk({tag, "_bits"}, 64'(mismatches()), 64'd0);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_q.size()));
        chk({tag, "_idle_after"}, {62'd0, ended_idle, final_sout}, 64'd3);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c;
        logic [3:0]  f;
        logic [5:0]  e;
        logic [7:0]  p;
        int          bad;

        rst = 1'b0;
        bus.valid = 1'b0;
        bus.C = '0;
        bus.FLAGS = '0;
        bus.ERR_FLAGS = '0;
        repeat (3) @(negedge clk);
        chk("reset_sout", 64'(bus.sout), 64'd1);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_sout", 64'(bus.sout), 64'd1);

        // Expected ctl payloads worked out by hand from the frame rules.
        tbl[0] = '{32'h0,         4'h0, 6'b100100, 11, 8'hC9};
        tbl[1] = '{32'h0,         4'h0, 6'b000001, 11, 8'h82};
        tbl[2] = '{32'hDEADBEEF,  4'h5, 6'b111111, 11, 8'hFF};
        tbl[3] = '{32'hFFFFFFFF,  4'hF, 6'b010000, 11, 8'hA0};
        tbl[4] = '{32'h0,         4'h0, 6'b000000, 55, 8'h00};
        tbl[5] = '{32'h0,         4'h1, 6'b000000, 55, 8'h0B};
        tbl[6] = '{32'h0,         4'h2, 6'b000000, 55, 8'h16};
        tbl[7] = '{32'h12345678,  4'h0, 6'b000000, 55, 8'h06};

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].c, tbl[i].f, tbl[i].e, -1);
            check_frame($sformatf("row%0d", i), tbl[i].c, tbl[i].f, tbl[i].e);
            chk($sformatf("row%0d_len", i), 64'(busy_cnt), 64'(tbl[i].len));
            chk($sformatf("row%0d_ctl", i), 64'(last_payload()), 64'(tbl[i].ctl));
        end
        chk("pkg_crc_12345678", 64'(nextCRC3_D37({32'h12345678, 1'b0, 4'h0}, 3'b000)), 64'd6);

        // Strobe during a frame must be dropped and leave the frame untouched.
        run_frame(32'h12345678, 4'h0, 6'd0, 10);
        check_frame("ignored", 32'h12345678, 4'h0, 6'd0);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.busy || !bus.sout) bad++;
        end
        chk("no_extra_frame", 64'(bad), 64'd0);

        // Back-to-back: second valid raised in the first cycle busy is low.
        run_frame(32'hA5A5_0F0F, 4'h9, 6'd0, -1);
        check_frame("b2b_first", 32'hA5A5_0F0F, 4'h9, 6'd0);
        run_frame(32'h0000_00FF, 4'h3, 6'd0, -1);
        check_frame("b2b_second", 32'h0000_00FF, 4'h3, 6'd0);
        chk("b2b_start_bit", 64'((cap.size() > 0) ? cap[0] : 1'b1), 64'd0);

        // Asynchronous reset in the middle of a data frame.
        bus.C = 32'h0; bus.FLAGS = 4'h0; bus.ERR_FLAGS = 6'h0;
        bus.valid = 1'b1;
        @(posedge clk);
        #1 bus.valid = 1'b0;
        repeat (21) @(negedge clk);
        chk("pre_reset_bit20", 64'(bus.sout), 64'd0);
        chk("pre_reset_busy", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("async_reset_sout", 64'(bus.sout), 64'd1);
        chk("async_reset_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.busy || !bus.sout) bad++;
        end
        chk("no_resume_after_reset", 64'(bad), 64'd0);

        for (int i = 0; i < 30; i++) begin
            c = $urandom;
            f = 4'($urandom_range(0, 15));
            e = 6'($urandom_range(1, 63));
            run_frame(c, f, e, -1);
            check_frame("rand_err", c, f, e);
        end

        for (int i = 0; i < 1000; i++) begin
            c = $urandom;
            f = 4'($urandom_range(0, 15));
            run_frame(c, f, 6'd0, -1);
            check_frame("sweep", c, f, 6'd0);
            p = last_payload();
            chk("sweep_crc", 64'(p[2:0]), 64'(ref_crc(c, f)));
            chk("sweep_payload7", 64'(p[7]), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
